// File: rtl/ex_commit.sv
// ============================================================================
// Module   : ex_commit
// Brief    : WB-stage exception/interrupt/ERTN commit controller with a held
//            fetch redirect and a post-redirect pipeline drain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_commit #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_wb_valid,
    input  logic [31:0] i_wb_pc,
    input  logic        i_wb_ex,
    input  logic [7:0]  i_wb_ecode,
    input  logic        i_wb_esubcode,
    input  logic [31:0] i_wb_vaddr,
    input  logic        i_wb_ertn,
    input  logic        i_has_int,
    input  logic [31:0] i_ex_entryPC,
    input  logic [31:0] i_new_pc,
    input  logic        i_redirect_ready,
    output logic        o_wb_ready,
    output logic        o_wb_commit,
    output logic        o_ex_en,
    output logic [7:0]  o_ecode,
    output logic        o_esubcode,
    output logic [31:0] o_pc,
    output logic [31:0] o_vaddr,
    output logic        o_ertn_flush,
    output logic        o_flush,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc
);

    localparam logic [7:0] c_ECODE_INT  = 8'h00;
    localparam logic [7:0] c_ECODE_ERTN = 8'h3F;
    localparam logic [3:0] c_DRAIN      = 4'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRAP  = 2'd1,
        S_REDIR = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_int_pending;
    logic        r_is_ertn;
    logic [3:0]  r_cnt;
    logic        r_ex_en;
    logic        r_ertn_flush;
    logic        r_flush;
    logic        r_redirect_valid;
    logic [7:0]  r_ecode;
    logic        r_esubcode;
    logic [31:0] r_pc;
    logic [31:0] r_vaddr;
    logic [31:0] r_redirect_pc;

    logic w_idle;
    logic w_take_ex;
    logic w_take_int;
    logic w_take_ertn;
    logic w_event;

    // Strict priority: synchronous exception, then interrupt, then ERTN.
    assign w_idle      = (r_state == S_IDLE);
    assign w_take_ex   = w_idle & i_wb_valid & i_wb_ex;
    assign w_take_int  = w_idle & i_wb_valid & ~i_wb_ex & r_int_pending;
    assign w_take_ertn = w_idle & i_wb_valid & ~i_wb_ex & ~r_int_pending & i_wb_ertn;
    assign w_event     = w_take_ex | w_take_int | w_take_ertn;

    // An interrupted instruction still retires: the CSR file resumes at ERA+4.
    assign o_wb_ready  = w_idle;
    assign o_wb_commit = w_idle & i_wb_valid & ~i_wb_ex;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state          <= S_IDLE;
            r_int_pending    <= 1'b0;
            r_is_ertn        <= 1'b0;
            r_cnt            <= 4'd0;
            r_ex_en          <= 1'b0;
            r_ertn_flush     <= 1'b0;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_ecode          <= 8'd0;
            r_esubcode       <= 1'b0;
            r_pc             <= 32'd0;
            r_vaddr          <= 32'd0;
            r_redirect_pc    <= 32'd0;
        end else begin
            // CSR-side fields are only non-zero during the single TRAP cycle,
            // because the CSR file consumes ecode without qualifying on ex_en.
            r_ex_en      <= 1'b0;
            r_ertn_flush <= 1'b0;
            r_ecode      <= 8'd0;
            r_esubcode   <= 1'b0;
            r_pc         <= 32'd0;
            r_vaddr      <= 32'd0;

            case (r_state)
                S_IDLE: begin
                    r_int_pending <= w_take_int ? 1'b0 : i_has_int;
                    if (w_take_ex) begin
                        r_ex_en    <= 1'b1;
                        r_ecode    <= i_wb_ecode;
                        r_esubcode <= i_wb_esubcode;
                        r_pc       <= i_wb_pc;
                        r_vaddr    <= i_wb_vaddr;
                    end else if (w_take_int) begin
                        r_ex_en    <= 1'b1;
                        r_ecode    <= c_ECODE_INT;
                        r_pc       <= i_wb_pc;
                    end else if (w_take_ertn) begin
                        r_ertn_flush <= 1'b1;
                        r_ecode      <= c_ECODE_ERTN;
                    end
                    if (w_event) begin
                        r_state   <= S_TRAP;
                        r_flush   <= 1'b1;
                        r_is_ertn <= w_take_ertn;
                    end
                end
                S_TRAP: begin
                    // Sampled here, before the CSR file applies this cycle's update.
                    r_redirect_pc    <= r_is_ertn ? i_new_pc : i_ex_entryPC;
                    r_redirect_valid <= 1'b1;
                    r_state          <= S_REDIR;
                end
                S_REDIR: begin
                    if (i_redirect_ready) begin
                        r_redirect_valid <= 1'b0;
                        r_flush          <= 1'b0;
                        r_cnt            <= c_DRAIN;
                        r_state          <= (c_DRAIN == 4'd0) ? S_IDLE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ex_en          = r_ex_en;
    assign o_ertn_flush     = r_ertn_flush;
    assign o_ecode          = r_ecode;
    assign o_esubcode       = r_esubcode;
    assign o_pc             = r_pc;
    assign o_vaddr          = r_vaddr;
    assign o_flush          = r_flush;
    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;

endmodule

`default_nettype wire

// File: tb/tb_ex_commit.sv
// ============================================================================
// Module   : tb_ex_commit
// Brief    : Self-checking bench for ex_commit (scoreboard of expected traps).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ex_commit;

    localparam logic [7:0] c_ECODE_ERTN = 8'h3F;
    localparam logic [7:0] c_ECODE_SYS  = 8'h0B;
    localparam logic [7:0] c_ECODE_ALE  = 8'h09;

    logic        clk;
    logic        rstn;
    logic        wb_valid, wb_ex, wb_esubcode, wb_ertn, has_int, redirect_ready;
    logic [31:0] wb_pc, wb_vaddr, ex_entryPC, new_pc;
    logic [7:0]  wb_ecode;
    logic        wb_ready, wb_commit, ex_en, esubcode, ertn_flush, flush, redirect_valid;
    logic [7:0]  ecode;
    logic [31:0] pc, vaddr, redirect_pc;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ex_en;
        logic        ertn;
        logic [7:0]  ecode;
        logic        esub;
        logic [31:0] pc;
        logic [31:0] vaddr;
        logic [31:0] target;
        logic        commit;
    } exp_t;

    exp_t sb[$];

    ex_commit #(.DRAIN_CYCLES(2)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_wb_valid       (wb_valid),
        .i_wb_pc          (wb_pc),
        .i_wb_ex          (wb_ex),
        .i_wb_ecode       (wb_ecode),
        .i_wb_esubcode    (wb_esubcode),
        .i_wb_vaddr       (wb_vaddr),
        .i_wb_ertn        (wb_ertn),
        .i_has_int        (has_int),
        .i_ex_entryPC     (ex_entryPC),
        .i_new_pc         (new_pc),
        .i_redirect_ready (redirect_ready),
        .o_wb_ready       (wb_ready),
        .o_wb_commit      (wb_commit),
        .o_ex_en          (ex_en),
        .o_ecode          (ecode),
        .o_esubcode       (esubcode),
        .o_pc             (pc),
        .o_vaddr          (vaddr),
        .o_ertn_flush     (ertn_flush),
        .o_flush          (flush),
        .o_redirect_valid (redirect_valid),
        .o_redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_wb();
        wb_valid = 0; wb_ex = 0; wb_ertn = 0; wb_ecode = 0;
        wb_esubcode = 0; wb_pc = 0; wb_vaddr = 0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (wb_ready) begin ok = 1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        rstn = 0;
        tick(); tick(); tick();
        rstn = 1;
        tick();
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL rst_wb_ready: got %0b exp 1", wb_ready); end
        checks++; if ({ex_en, ertn_flush, flush, redirect_valid, wb_commit} !== 5'b0) begin errors++; $display("FAIL rst_pulses: got %05b exp 00000", {ex_en, ertn_flush, flush, redirect_valid, wb_commit}); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect_pc: got %h exp 0", redirect_pc); end
        checks++; if ({ecode, esubcode, pc, vaddr} !== 73'h0) begin errors++; $display("FAIL rst_fields: got %h/%h/%h/%h exp 0", ecode, esubcode, pc, vaddr); end
    endtask

    task automatic test_idle_invalid();
        clear_wb(); wb_ex = 1; wb_ecode = c_ECODE_SYS;
        #1;
        checks++; if (wb_commit !== 1'b0) begin errors++; $display("FAIL inv_commit: got %0b exp 0", wb_commit); end
        tick(); clear_wb();
        checks++; if ({ex_en, flush, wb_ready} !== 3'b001) begin errors++; $display("FAIL inv_no_trap: got %03b exp 001", {ex_en, flush, wb_ready}); end
    endtask

    task automatic test_syscall();
        exp_t e;
        bit ok;
        redirect_ready = 1;
        clear_wb(); wb_valid = 1; wb_ex = 1; wb_ecode = c_ECODE_SYS; wb_pc = 32'h1C000100;
        ex_entryPC = 32'h1C008000;
        sb.push_back('{ex_en: 1'b1, ertn: 1'b0, ecode: c_ECODE_SYS, esub: 1'b0, pc: 32'h1C000100,
                       vaddr: 32'h0, target: 32'h1C008000, commit: 1'b0});
        #1;
        checks++; if (wb_commit !== sb[0].commit) begin errors++; $display("FAIL sys_commit: got %0b exp %0b", wb_commit, sb[0].commit); end
        tick(); clear_wb();
        e = sb.pop_front();
        checks++; if ({ex_en, ertn_flush, flush} !== {e.ex_en, e.ertn, 1'b1}) begin errors++; $display("FAIL sys_trap_pulses: got %03b exp %03b", {ex_en, ertn_flush, flush}, {e.ex_en, e.ertn, 1'b1}); end
        checks++; if (ecode !== e.ecode) begin errors++; $display("FAIL sys_ecode: got %h exp %h", ecode, e.ecode); end
        checks++; if (pc !== e.pc) begin errors++; $display("FAIL sys_pc: got %h exp %h", pc, e.pc); end
        tick();
        ex_entryPC = 32'hDEAD0000;
        checks++; if ({redirect_valid, flush, ex_en} !== 3'b110) begin errors++; $display("FAIL sys_redir: got %03b exp 110", {redirect_valid, flush, ex_en}); end
        checks++; if (redirect_pc !== e.target) begin errors++; $display("FAIL sys_redirect_pc: got %h exp %h", redirect_pc, e.target); end
        checks++; if (ecode !== 8'h0) begin errors++; $display("FAIL sys_ecode_cleared: got %h exp 0", ecode); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL sys_idle_timeout: got wb_ready 0 exp 1"); end
    endtask

    task automatic test_ale();
        exp_t e;
        bit ok;
        clear_wb(); wb_valid = 1; wb_ex = 1; wb_ecode = c_ECODE_ALE; wb_esubcode = 1;
        wb_pc = 32'h1C000300; wb_vaddr = 32'h80000003; ex_entryPC = 32'h1C008000;
        sb.push_back('{ex_en: 1'b1, ertn: 1'b0, ecode: c_ECODE_ALE, esub: 1'b1, pc: 32'h1C000300,
                       vaddr: 32'h80000003, target: 32'h1C008000, commit: 1'b0});
        #1;
        checks++; if (vaddr !== 32'h0) begin errors++; $display("FAIL ale_vaddr_pre: got %h exp 0", vaddr); end
        tick(); clear_wb();
        e = sb.pop_front();
        checks++; if ({ex_en, ecode, esubcode} !== {e.ex_en, e.ecode, e.esub}) begin errors++; $display("FAIL ale_trap: got %0b/%h/%0b exp %0b/%h/%0b", ex_en, ecode, esubcode, e.ex_en, e.ecode, e.esub); end
        checks++; if (vaddr !== e.vaddr) begin errors++; $display("FAIL ale_vaddr: got %h exp %h", vaddr, e.vaddr); end
        tick();
        checks++; if ({vaddr, esubcode} !== 33'h0) begin errors++; $display("FAIL ale_vaddr_post: got %h/%0b exp 0", vaddr, esubcode); end
        wait_idle(ok);
        checks++; if (!ok || vaddr !== 32'h0) begin errors++; $display("FAIL ale_idle: got ready %0b vaddr %h exp 1/0", ok, vaddr); end
    endtask

    task automatic test_interrupt();
        exp_t e;
        bit ok;
        clear_wb(); has_int = 1;
        tick();
        wb_valid = 1; wb_pc = 32'h1C000200; ex_entryPC = 32'h1C008800;
        sb.push_back('{ex_en: 1'b1, ertn: 1'b0, ecode: 8'h00, esub: 1'b0, pc: 32'h1C000200,
                       vaddr: 32'h0, target: 32'h1C008800, commit: 1'b1});
        #1;
        checks++; if (wb_commit !== sb[0].commit) begin errors++; $display("FAIL int_commit: got %0b exp %0b", wb_commit, sb[0].commit); end
        tick(); clear_wb(); has_int = 0;
        e = sb.pop_front();
        checks++; if ({ex_en, ertn_flush, ecode} !== {e.ex_en, e.ertn, e.ecode}) begin errors++; $display("FAIL int_trap: got %0b/%0b/%h exp %0b/%0b/%h", ex_en, ertn_flush, ecode, e.ex_en, e.ertn, e.ecode); end
        checks++; if ({pc, vaddr} !== {e.pc, e.vaddr}) begin errors++; $display("FAIL int_pc: got %h/%h exp %h/%h", pc, vaddr, e.pc, e.vaddr); end
        tick();
        checks++; if (redirect_pc !== e.target) begin errors++; $display("FAIL int_redirect_pc: got %h exp %h", redirect_pc, e.target); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL int_idle_timeout: got wb_ready 0 exp 1"); end
        wb_valid = 1; wb_pc = 32'h1C000204;
        tick(); clear_wb();
        checks++; if ({ex_en, flush, wb_ready} !== 3'b001) begin errors++; $display("FAIL int_pending_cleared: got %03b exp 001", {ex_en, flush, wb_ready}); end
    endtask

    task automatic test_int_latency();
        exp_t e;
        bit ok;
        clear_wb(); has_int = 1; wb_valid = 1; wb_pc = 32'h1C000400;
        #1;
        checks++; if (wb_commit !== 1'b1) begin errors++; $display("FAIL lat_commit0: got %0b exp 1", wb_commit); end
        tick();
        checks++; if ({ex_en, flush, wb_ready} !== 3'b001) begin errors++; $display("FAIL lat_no_trap: got %03b exp 001", {ex_en, flush, wb_ready}); end
        has_int = 0; wb_pc = 32'h1C000404; ex_entryPC = 32'h1C009000;
        sb.push_back('{ex_en: 1'b1, ertn: 1'b0, ecode: 8'h00, esub: 1'b0, pc: 32'h1C000404,
                       vaddr: 32'h0, target: 32'h1C009000, commit: 1'b1});
        tick(); clear_wb();
        e = sb.pop_front();
        checks++; if ({ex_en, ecode, pc} !== {e.ex_en, e.ecode, e.pc}) begin errors++; $display("FAIL lat_trap: got %0b/%h/%h exp %0b/%h/%h", ex_en, ecode, pc, e.ex_en, e.ecode, e.pc); end
        tick();
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL lat_idle_timeout: got wb_ready 0 exp 1"); end
    endtask

    task automatic test_ertn(input bit with_ex);
        exp_t e;
        bit ok;
        clear_wb(); wb_valid = 1; wb_ertn = 1; wb_pc = 32'h1C000500;
        ex_entryPC = 32'h1C008000; new_pc = 32'h1C000104;
        if (with_ex) begin
            wb_ex = 1; wb_ecode = c_ECODE_SYS;
            sb.push_back('{ex_en: 1'b1, ertn: 1'b0, ecode: c_ECODE_SYS, esub: 1'b0, pc: 32'h1C000500,
                           vaddr: 32'h0, target: 32'h1C008000, commit: 1'b0});
        end else begin
            sb.push_back('{ex_en: 1'b0, ertn: 1'b1, ecode: c_ECODE_ERTN, esub: 1'b0, pc: 32'h0,
                           vaddr: 32'h0, target: 32'h1C000104, commit: 1'b1});
        end
        #1;
        checks++; if (wb_commit !== sb[0].commit) begin errors++; $display("FAIL ertn%0d_commit: got %0b exp %0b", with_ex, wb_commit, sb[0].commit); end
        tick(); clear_wb();
        e = sb.pop_front();
        checks++; if ({ex_en, ertn_flush, flush} !== {e.ex_en, e.ertn, 1'b1}) begin errors++; $display("FAIL ertn%0d_pulses: got %03b exp %03b", with_ex, {ex_en, ertn_flush, flush}, {e.ex_en, e.ertn, 1'b1}); end
        checks++; if ({ecode, pc} !== {e.ecode, e.pc}) begin errors++; $display("FAIL ertn%0d_fields: got %h/%h exp %h/%h", with_ex, ecode, pc, e.ecode, e.pc); end
        tick();
        new_pc = 32'h0; ex_entryPC = 32'h0;
        checks++; if (redirect_pc !== e.target || ertn_flush !== 1'b0) begin errors++; $display("FAIL ertn%0d_redirect: got %h/%0b exp %h/0", with_ex, redirect_pc, ertn_flush, e.target); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ertn%0d_idle_timeout: got wb_ready 0 exp 1", with_ex); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        redirect_ready = 0;
        clear_wb(); wb_valid = 1; wb_ex = 1; wb_ecode = c_ECODE_SYS; wb_pc = 32'h1C000600;
        ex_entryPC = 32'h1C00A000;
        sb.push_back('{ex_en: 1'b1, ertn: 1'b0, ecode: c_ECODE_SYS, esub: 1'b0, pc: 32'h1C000600,
                       vaddr: 32'h0, target: 32'h1C00A000, commit: 1'b0});
        tick(); clear_wb();
        e = sb.pop_front();
        checks++; if ({ex_en, pc} !== {e.ex_en, e.pc}) begin errors++; $display("FAIL bp_trap: got %0b/%h exp %0b/%h", ex_en, pc, e.ex_en, e.pc); end
        for (int k = 0; k < 5; k++) begin
            tick();
            ex_entryPC = 32'h11110000 + k;
            checks++; if ({redirect_valid, flush, wb_ready} !== 3'b110 || redirect_pc !== e.target) begin errors++; $display("FAIL bp_hold%0d: got %03b pc %h exp 110 pc %h", k, {redirect_valid, flush, wb_ready}, redirect_pc, e.target); end
        end
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        checks++; if ({wb_ready, flush, redirect_valid} !== 3'b000) begin errors++; $display("FAIL bp_drain1: got %03b exp 000", {wb_ready, flush, redirect_valid}); end
        tick();
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL bp_drain2: got %0b exp 0", wb_ready); end
        tick();
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_r3: got %0b exp 1", wb_ready); end
        redirect_ready = 1;
    endtask

    task automatic test_reset_redir();
        redirect_ready = 0;
        clear_wb(); wb_valid = 1; wb_ex = 1; wb_ecode = c_ECODE_SYS; wb_pc = 32'h1C000700;
        has_int = 1;
        tick(); clear_wb(); has_int = 0;
        tick();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL rr_in_redir: got %0b exp 1", redirect_valid); end
        rstn = 0;
        tick();
        rstn = 1;
        checks++; if ({redirect_valid, flush, wb_ready} !== 3'b001) begin errors++; $display("FAIL rr_after_reset: got %03b exp 001", {redirect_valid, flush, wb_ready}); end
        redirect_ready = 1;
        wb_valid = 1; wb_pc = 32'h1C000800;
        tick(); clear_wb();
        checks++; if ({ex_en, flush, wb_ready} !== 3'b001) begin errors++; $display("FAIL rr_int_pending_reset: got %03b exp 001", {ex_en, flush, wb_ready}); end
    endtask

    initial begin
        rstn = 0; has_int = 0; redirect_ready = 0;
        ex_entryPC = 0; new_pc = 0;
        clear_wb();
        test_reset();
        test_idle_invalid();
        test_syscall();
        test_ale();
        test_interrupt();
        test_int_latency();
        test_ertn(1'b0);
        test_ertn(1'b1);
        test_backpressure();
        test_reset_redir();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_empty: got %0d entries exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
